mem_dump: RTL

- Host-side reader for the core's data memory, at the opposite end of the core's store path.
- Armed by a start pulse, it waits for the core to raise done, then reads a programmed address window from dataMem.
- Streams the words out on a valid/ready interface with address, last flag and a running 8-bit checksum.
- Owns the dataMem read address only while the core is halted; the top-level muxes mem_addr onto dataMem when mux_sel is high.

---
 rtl/mem_dump_pkg.sv | 17 +
 rtl/mem_dump_if.sv | 32 +++
 rtl/dump_out_reg.sv | 51 +++++
 rtl/mem_dump.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and default widths for the data-memory dump reader.
// Imported by the interface, the output register and the top level.
package mem_dump_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    READ,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/mem_dump_if.sv
// Valid/ready stream carrying dumped words with address and last flag.
// The dump block is the master, the host-side consumer the slave.
interface mem_dump_if
  import mem_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_data;
  logic [AW-1:0] dout_addr;
  logic          dout_last;

  modport master (
    output dout_valid,
    output dout_data,
    output dout_addr,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout_valid,
    input  dout_data,
    input  dout_addr,
    input  dout_last,
    output dout_ready
  );

endinterface

// File: rtl/dump_out_reg.sv
// Single-entry valid/ready output register plus running checksum
// of every word the consumer accepts.
module dump_out_reg #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clr,
  input  logic [DW-1:0] inData,
  input  logic [AW-1:0] inAddr,
  input  logic          inLast,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic [DW-1:0] checksum
);

  logic accept;

  assign accept = valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      data     <= '0;
      addr     <= '0;
      last     <= 1'b0;
      checksum <= '0;
    end else begin
      // clr only fires while idle, so it never races an accept
      if (clr) begin
        checksum <= '0;
      end else if (accept) begin
        checksum <= checksum + data;
      end
      if (load) begin
        valid <= 1'b1;
        data  <= inData;
        addr  <= inAddr;
        last  <= inLast;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_dump.sv
// Host-side dataMem reader: waits for core halt, then streams a window
// of words out with address, last flag and checksum.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_cnt,
  input  logic          core_done,
  output logic          mux_sel,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  mem_dump_if.master    dout,
  output logic          busy,
  output logic          finished,
  output logic [DW-1:0] checksum
);

  localparam logic [CW-1:0] MaxCnt = CW'(1) << AW;

  state_t        state;
  logic [AW-1:0] addrQ;
  logic [CW-1:0] remQ;
  logic [CW-1:0] cntClamp;
  logic          armOk;
  logic          load;
  logic          lastWord;

  assign cntClamp = (word_cnt > MaxCnt) ? MaxCnt : word_cnt;
  assign armOk    = start && (state == IDLE || state == FINISH);
  assign load     = (state == READ) && (!dout.dout_valid || dout.dout_ready);
  assign lastWord = (remQ == CW'(1));
  assign mem_addr = addrQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addrQ    <= '0;
      remQ     <= '0;
      mux_sel  <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FINISH: begin
          if (start) begin
            state    <= WAIT_DONE;
            addrQ    <= base_addr;
            remQ     <= cntClamp;
            busy     <= 1'b1;
            finished <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (core_done) begin
            if (remQ != '0) begin
              state   <= READ;
              mux_sel <= 1'b1;
            end else begin
              state    <= FINISH;
              busy     <= 1'b0;
              finished <= 1'b1;
            end
          end
        end
        READ: begin
          if (load) begin
            addrQ <= addrQ + 1'b1;
            remQ  <= remQ - 1'b1;
            if (lastWord) state <= DRAIN;
          end
        end
        DRAIN: begin
          // last word is already registered; wait for its accept
          if (dout.dout_ready) begin
            state    <= FINISH;
            mux_sel  <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dump_out_reg #(
    .AW(AW),
    .DW(DW)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .clr      (armOk),
    .inData   (mem_rd_data),
    .inAddr   (addrQ),
    .inLast   (lastWord),
    .ready    (dout.dout_ready),
    .valid    (dout.dout_valid),
    .data     (dout.dout_data),
    .addr     (dout.dout_addr),
    .last     (dout.dout_last),
    .checksum (checksum)
  );

endmodule
